imm_ext_pipe: RTL and testbench

//  Parametrised, registered immediate-extension stage for the DLX datapath.

---
 rtl/imm_ext_pipe_if.sv | 33 +++
 rtl/imm_ext_pipe.sv | 98 +++++++++
 tb/tb_imm_ext_pipe.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_ext_pipe_if.sv
// ============================================================================
// Module : imm_ext_pipe_if
// Brief  : Valid/ready handshake bundle for the immediate-extension stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface imm_ext_pipe_if #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [IMM_W-1:0]  in_imm;
    logic [1:0]        in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       ext_cnt;

    // master = producer of immediates / consumer of results
    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_data, ext_cnt
    );

    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_data, ext_cnt
    );
endinterface

`default_nettype wire

// File: rtl/imm_ext_pipe.sv
// ============================================================================
// Module : imm_ext_pipe
// Brief  : Registered immediate extension (SEXT/ZEXT/LHI/SEXT_B) with skid buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imm_ext_pipe #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  wire logic     clk,
    input  wire logic     reset,
    imm_ext_pipe_if.slave bus
);
    localparam int         FILL_W        = DATA_W - IMM_W;
    localparam logic [1:0] C_MODE_SEXT   = 2'd0;
    localparam logic [1:0] C_MODE_ZEXT   = 2'd1;
    localparam logic [1:0] C_MODE_LHI    = 2'd2;
    localparam logic [1:0] C_MODE_SEXT_B = 2'd3;

    logic [DATA_W-1:0] r_or_data;
    logic              r_or_valid;
    logic [DATA_W-1:0] r_sk_data;
    logic              r_sk_valid;
    logic [15:0]       r_ext_cnt;

    logic [DATA_W-1:0] w_ext;
    logic              w_fill_ones;
    logic              w_accept;
    logic              w_xfer;

    always_comb begin
        w_ext       = '0;
        w_fill_ones = 1'b0;
        case (bus.in_mode)
            C_MODE_SEXT: begin
                w_ext       = {{FILL_W{bus.in_imm[IMM_W-1]}}, bus.in_imm};
                w_fill_ones = bus.in_imm[IMM_W-1];
            end
            C_MODE_ZEXT: w_ext = {{FILL_W{1'b0}}, bus.in_imm};
            C_MODE_LHI:  w_ext = {bus.in_imm, {FILL_W{1'b0}}};
            C_MODE_SEXT_B: begin
                w_ext       = {{(DATA_W-8){bus.in_imm[7]}}, bus.in_imm[7:0]};
                w_fill_ones = bus.in_imm[7];
            end
            default: begin
                w_ext       = '0;
                w_fill_ones = 1'b0;
            end
        endcase
    end

    // Ready depends only on stored state, never on out_ready.
    assign bus.in_ready  = ~r_sk_valid & ~reset;
    assign bus.out_valid = r_or_valid;
    assign bus.out_data  = r_or_data;
    assign bus.ext_cnt   = r_ext_cnt;

    assign w_accept = bus.in_valid & bus.in_ready;
    assign w_xfer   = r_or_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_or_data  <= '0;
            r_or_valid <= 1'b0;
            r_sk_data  <= '0;
            r_sk_valid <= 1'b0;
            r_ext_cnt  <= '0;
        end else begin
            if (!r_or_valid || w_xfer) begin
                // Skid entry is older than any new input, so it refills OR first.
                if (r_sk_valid) begin
                    r_or_data  <= r_sk_data;
                    r_or_valid <= 1'b1;
                    r_sk_valid <= w_accept;
                    if (w_accept) begin
                        r_sk_data <= w_ext;
                    end
                end else if (w_accept) begin
                    r_or_data  <= w_ext;
                    r_or_valid <= 1'b1;
                end else begin
                    r_or_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_sk_data  <= w_ext;
                r_sk_valid <= 1'b1;
            end

            if (w_accept && w_fill_ones) begin
                r_ext_cnt <= r_ext_cnt + 16'd1;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_imm_ext_pipe.sv
// ============================================================================
// Module : tb_imm_ext_pipe
// Brief  : Scoreboard-based self-checking bench for imm_ext_pipe (16/32 and 12/24).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imm_ext_pipe;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    imm_ext_pipe_if #(.IMM_W(16), .DATA_W(32)) bus ();
    imm_ext_pipe_if #(.IMM_W(12), .DATA_W(24)) bus2 ();

    imm_ext_pipe #(.IMM_W(16), .DATA_W(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    imm_ext_pipe #(.IMM_W(12), .DATA_W(24)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    int          checks     = 0;
    int          failures   = 0;
    int          out_seen   = 0;
    int          stall_cnt  = 0;
    logic [15:0] exp_cnt    = 16'd0;
    logic [31:0] sb[$];

    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
        case (mode)
            2'd0:    return {{16{imm[15]}}, imm};
            2'd1:    return {16'h0000, imm};
            2'd2:    return {imm, 16'h0000};
            default: return {{24{imm[7]}}, imm[7:0]};
        endcase
    endfunction

    // Scoreboard: push on accept, pop/compare on transfer.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            exp_cnt = 16'd0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                logic [31:0] exp;
                checks++;
                out_seen++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_underflow: got out_data=%h with no expected entry", bus.out_data);
                end else begin
                    exp = sb.pop_front();
                    if (bus.out_data !== exp) begin
                        failures++;
                        $display("FAIL sb_data: got %h expected %h", bus.out_data, exp);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(ref_ext(bus.in_imm, bus.in_mode));
                if ((bus.in_mode == 2'd0 && bus.in_imm[15]) || (bus.in_mode == 2'd3 && bus.in_imm[7]))
                    exp_cnt = exp_cnt + 16'd1;
            end
        end
    end

    task automatic send(input logic [15:0] imm, input logic [1:0] mode);
        logic acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_imm   = imm;
        bus.in_mode  = mode;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            stall_cnt++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: imm=%h not accepted, in_ready=%b", imm, bus.in_ready);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 60; n++) begin
            if (sb.size() == 0 && !bus.out_valid) break;
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain: pending=%0d out_valid=%b expected 0/0", sb.size(), bus.out_valid);
        end
        checks++;
        if (bus.ext_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL ext_cnt: got %0d expected %0d", bus.ext_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.ext_cnt !== 16'h0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: valid=%b data=%h cnt=%h ready=%b expected 0/0/0/0",
                     bus.out_valid, bus.out_data, bus.ext_cnt, bus.in_ready);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_sext();
        bus.out_ready = 1'b1;
        send(16'h8001, 2'd0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFF8001 || bus.ext_cnt !== 16'd1) begin
            failures++;
            $display("FAIL sext_latency: valid=%b data=%h cnt=%0d expected 1/FFFF8001/1",
                     bus.out_valid, bus.out_data, bus.ext_cnt);
        end
        drain();
    endtask

    task automatic test_modes();
        bus.out_ready = 1'b1;
        send(16'h8001, 2'd1);
        checks++;
        if (bus.out_data !== 32'h00008001) begin
            failures++;
            $display("FAIL zext: got %h expected 00008001", bus.out_data);
        end
        send(16'h1234, 2'd2);
        checks++;
        if (bus.out_data !== 32'h12340000) begin
            failures++;
            $display("FAIL lhi: got %h expected 12340000", bus.out_data);
        end
        send(16'h1280, 2'd3);
        checks++;
        if (bus.out_data !== 32'hFFFFFF80) begin
            failures++;
            $display("FAIL sext_b: got %h expected FFFFFF80", bus.out_data);
        end
        send(16'h7F7F, 2'd3);
        send(16'h7FFF, 2'd0);
        drain();
    endtask

    task automatic test_backpressure();
        int base;
        base = out_seen;
        bus.out_ready = 1'b0;
        send(16'h0001, 2'd1);
        send(16'h0002, 2'd1);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready: got %b expected 0", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_imm   = 16'h0003;
        bus.in_mode  = 2'd1;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1 || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold: valid=%b data=%h ready=%b expected 1/00000001/0",
                         bus.out_valid, bus.out_data, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        send(16'h0003, 2'd1);
        drain();
        checks++;
        if (out_seen - base != 3) begin
            failures++;
            $display("FAIL bp_count: got %0d outputs expected 3", out_seen - base);
        end
    endtask

    task automatic test_stream();
        int base;
        base = out_seen;
        stall_cnt = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++)
            send(16'($urandom), 2'($urandom_range(0, 3)));
        drain();
        checks++;
        if (stall_cnt != 0) begin
            failures++;
            $display("FAIL stream_stall: in_ready low %0d times expected 0", stall_cnt);
        end
        checks++;
        if (out_seen - base != 100) begin
            failures++;
            $display("FAIL stream_count: got %0d outputs expected 100", out_seen - base);
        end
    endtask

    task automatic test_random_backpressure();
        int  base;
        bit  done;
        base = out_seen;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++)
                    send(16'($urandom), 2'($urandom_range(0, 3)));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();
        checks++;
        if (out_seen - base != 60) begin
            failures++;
            $display("FAIL rbp_count: got %0d outputs expected 60", out_seen - base);
        end
    endtask

    task automatic test_mid_reset();
        bus.out_ready = 1'b0;
        send(16'hFFFF, 2'd0);
        send(16'h00AA, 2'd3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ext_cnt !== 16'd0 || bus.out_data !== 32'h0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: valid=%b cnt=%0d data=%h ready=%b expected 0/0/0/0",
                     bus.out_valid, bus.ext_cnt, bus.out_data, bus.in_ready);
        end
        reset = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL stale_after_reset: valid=%b ready=%b expected 0/1", bus.out_valid, bus.in_ready);
            end
        end
        send(16'h0042, 2'd2);
        drain();
    endtask

    task automatic test_param_12_24();
        logic [11:0] imms[4]  = '{12'h800, 12'hABC, 12'h800, 12'hF7F};
        logic [1:0]  modes[4] = '{2'd0, 2'd2, 2'd1, 2'd3};
        logic [23:0] exps[4]  = '{24'hFFF800, 24'hABC000, 24'h000800, 24'h00007F};
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus2.in_valid = 1'b1;
            bus2.in_imm   = imms[i];
            bus2.in_mode  = modes[i];
            @(posedge clk);
            #1;
            checks++;
            if (bus2.out_valid !== 1'b1 || bus2.out_data !== exps[i]) begin
                failures++;
                $display("FAIL p12_24_case%0d: valid=%b data=%h expected 1/%h",
                         i, bus2.out_valid, bus2.out_data, exps[i]);
            end
        end
        bus2.in_valid = 1'b0;
        checks++;
        if (bus2.ext_cnt !== 16'd1) begin
            failures++;
            $display("FAIL p12_24_cnt: got %0d expected 1", bus2.ext_cnt);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_imm     = '0;
        bus.in_mode    = '0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_imm    = '0;
        bus2.in_mode   = '0;
        bus2.out_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_sext();
        test_modes();
        test_backpressure();
        test_stream();
        test_random_backpressure();
        test_mid_reset();
        test_param_12_24();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
